spi_ram_bridge: RTL and testbench
=================================

SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_WIDTH, 8, memory word and frame payload width; legal range 4..32.
- ADDR_WIDTH, 8, address width; ADDR_WIDTH <= DATA_WIDTH.
- MEM_DEPTH, 256, number of words; 1..2^ADDR_WIDTH.
- AUTO_INC, 0, 1 = address post-increments after each data access.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, input, 1, SPI serial clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- SS_n, input, 1, active-low slave select.
- MOSI, input, 1, serial data in, MSB first.
- MISO, output, 1, serial data out, MSB first, registered.
- busy, output, 1, high whenever the state is not IDLE, registered.
REQ-003 Clocking and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 A frame SHALL be F = 2 + DATA_WIDTH bits: cmd[1:0], then payload[DATA_WIDTH-1:0].
REQ-005 Commands SHALL be:
- 00 = write address: waddr <= payload[ADDR_WIDTH-1:0].
- 01 = write data: mem[waddr] <= payload.
- 10 = read address: raddr <= payload[ADDR_WIDTH-1:0].
- 11 = read data: shift out mem[raddr].
REQ-006 The state machine SHALL have the states IDLE, RX, EXEC and TX.
REQ-007 IDLE: a rising edge sampling SS_n=0 SHALL go to RX with bit counter 0 and capture no bit.
REQ-008 RX: each edge SHALL shift MOSI into the shift register; the edge capturing bit F goes to EXEC.
REQ-009 EXEC SHALL last exactly one edge and apply the command.
- Latency: the command takes effect on edge E(F+1), where E0 is the edge that left IDLE.
REQ-010 EXEC for commands 00, 01 and 10 SHALL return to RX with counter 0, so back-to-back frames are allowed without raising SS_n.
REQ-011 EXEC for command 11 SHALL load dout <= mem[raddr] and go to TX.
REQ-012 TX SHALL drive dout MSB first on MISO, one bit per edge, on edges E(F+2)..E(F+1+DATA_WIDTH), then return to RX with counter 0.
- MOSI is ignored during TX.
REQ-013 MISO SHALL be 0 in every state other than TX.
REQ-014 With AUTO_INC=1, each 01 SHALL post-increment waddr and each 11 SHALL post-increment raddr.
- Both wrap from MEM_DEPTH-1 to 0.
- With AUTO_INC=0 the addresses are unchanged by data accesses.
REQ-015 Out-of-range accesses (address >= MEM_DEPTH) SHALL behave as follows:
- A write is discarded.
- A read returns all zeros.
- The auto-increment is still applied, wrapping to 0.
REQ-016 SS_n sampled high on any edge in any state SHALL force IDLE, with:
- the partial frame discarded and no memory or address change;
- an in-progress TX truncated and MISO 0 from that edge.
REQ-017 If SS_n rises on the EXEC edge, the command SHALL still complete and the state SHALL go to IDLE.
REQ-018 waddr and raddr SHALL be independent registers and SHALL persist across frames and SS_n deassertion.
REQ-019 Memory SHALL be a single-port array with one access per EXEC cycle.
REQ-020 busy SHALL be 0 in IDLE and 1 in RX, EXEC and TX.

Reset
REQ-021 While rst_n=0, asynchronously and independent of clk, the block SHALL hold:
- state IDLE, MISO=0, busy=0;
- waddr=0, raddr=0, dout=0;
- shift register and bit counter at 0.
REQ-022 Memory contents SHALL NOT be reset; after reset they are undefined until written.
REQ-023 A reset asserted mid-frame SHALL abort the frame with no memory write for that frame.

Verification
REQ-024 The bench SHALL cover these scenarios (defaults unless stated):
- Basic write/read: frames 00+0x05, 01+0xA7, 10+0x05, 11+0x00 in one SS_n low window -> MISO shifts 1,0,1,0,0,1,1,1 on the 8 edges after the read EXEC; busy stays high throughout.
- Auto-increment burst, AUTO_INC=1: 00+0xFE, then 01+0x11, 01+0x22, 01+0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap); 10+0xFE, then three 11 frames -> 0x11, 0x22, 0x33.
- Abort: SS_n raised after 6 bits of 01+0x55 at waddr 0x10 holding 0x99 -> mem[0x10] stays 0x99; state IDLE; MISO=0.
- Out of range, MEM_DEPTH=200: write 0xC8 <- 0x77, then read 0xC8 -> MISO all zeros; no in-range word altered.
- Reset mid-TX: rst_n pulsed low during bit 3 of a read -> MISO=0 and busy=0 immediately; waddr=raddr=0; previously written mem[0x05]=0xA7 still reads 0xA7.
- Parameter sweep, DATA_WIDTH=16, ADDR_WIDTH=10, MEM_DEPTH=1024 -> 18-bit frames; write then read of 0xBEEF at 0x3FF returns 0xBEEF MSB first.

Source files
------------

// File: rtl/spi_ram_bridge.sv
// SPI-slave bridge to a small word RAM: 2-bit command plus payload frames set
// independent write/read addresses, write a word, or shift a word back out MSB first.
module spi_ram_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy
);

    localparam int FRAME_LEN = DATA_WIDTH + 2;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]    LP_LAST_RX   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]    LP_LAST_TX   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] LP_DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_LAST_ADDR = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_EXEC, ST_TX} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [FRAME_LEN-1:0]    r_shift;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_miso;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [1:0]              w_cmd;
    logic [DATA_WIDTH-1:0]   w_payload;
    logic                    w_waddr_ok;
    logic                    w_raddr_ok;
    logic [ADDR_WIDTH-1:0]   w_waddr_inc;
    logic [ADDR_WIDTH-1:0]   w_raddr_inc;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_cmd      = r_shift[FRAME_LEN-1 -: 2];
    assign w_payload  = r_shift[DATA_WIDTH-1:0];
    assign w_waddr_ok = {1'b0, r_waddr} < LP_DEPTH;
    assign w_raddr_ok = {1'b0, r_raddr} < LP_DEPTH;
    // Out-of-range addresses also wrap to 0 on increment
    assign w_waddr_inc = ({1'b0, r_waddr} >= LP_LAST_ADDR) ? '0 : r_waddr + 1'b1;
    assign w_raddr_inc = ({1'b0, r_raddr} >= LP_LAST_ADDR) ? '0 : r_raddr + 1'b1;
    assign w_rdata     = w_raddr_ok ? r_mem[r_raddr] : '0;

    assign MISO = r_miso;
    assign busy = r_busy;

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && r_state == ST_EXEC && w_cmd == 2'b01 && w_waddr_ok) begin
            r_mem[r_waddr] <= w_payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_waddr <= '0;
            r_raddr <= '0;
            r_dout  <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_miso <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!SS_n) begin
                        r_state <= ST_RX;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_RX: begin
                    if (SS_n) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_shift <= {r_shift[FRAME_LEN-2:0], MOSI};
                        if (r_cnt == LP_LAST_RX) begin
                            r_state <= ST_EXEC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    case (w_cmd)
                        2'b00: r_waddr <= w_payload[ADDR_WIDTH-1:0];
                        2'b01: if (AUTO_INC != 0) r_waddr <= w_waddr_inc;
                        2'b10: r_raddr <= w_payload[ADDR_WIDTH-1:0];
                        default: begin
                            r_dout <= w_rdata;
                            if (AUTO_INC != 0) r_raddr <= w_raddr_inc;
                        end
                    endcase
                    r_cnt <= '0;
                    // The command completes even if SS_n rose on this edge
                    if (SS_n) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_cmd == 2'b11) begin
                        r_state <= ST_TX;
                    end else begin
                        r_state <= ST_RX;
                    end
                end
                ST_TX: begin
                    if (SS_n) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_miso <= r_dout[DATA_WIDTH-1];
                        r_dout <= {r_dout[DATA_WIDTH-2:0], 1'b0};
                        if (r_cnt == LP_LAST_TX) begin
                            r_state <= ST_RX;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed bench for spi_ram_bridge: four instances (default, auto-increment,
// short memory, 16-bit words) driven frame by frame with hand-computed expectations.
module tb_spi_ram_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss   [4];
    logic mosi [4];
    logic miso [4];
    logic busy [4];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss[0]), .MOSI(mosi[0]), .MISO(miso[0]), .busy(busy[0]));
    spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss[1]), .MOSI(mosi[1]), .MISO(miso[1]), .busy(busy[1]));
    spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss[2]), .MOSI(mosi[2]), .MISO(miso[2]), .busy(busy[2]));
    spi_ram_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .AUTO_INC(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss[3]), .MOSI(mosi[3]), .MISO(miso[3]), .busy(busy[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int k, input logic [1:0] cmd, input logic [31:0] pl,
                             input int dw, input int nbits);
        logic [33:0] fr;
        fr = (34'(cmd) << dw) | 34'(pl);
        for (int i = 0; i < nbits; i++) begin
            mosi[k] = fr[dw + 1 - i];
            tick();
        end
        mosi[k] = 1'b0;
    endtask

    task automatic frame(input int k, input logic [1:0] cmd, input logic [31:0] pl,
                         input int dw, input logic [31:0] exp_rd, input string name);
        logic [31:0] rd;
        rd = '0;
        send_bits(k, cmd, pl, dw, dw + 2);
        tick();
        if (cmd == 2'b11) begin
            n_vec++;
            if (miso[k] !== 1'b0) begin
                n_err++;
                $display("FAIL %s pre-tx MISO: got %b expected 0", name, miso[k]);
            end
            for (int i = 0; i < dw; i++) begin
                tick();
                rd = {rd[30:0], miso[k]};
            end
            n_vec++;
            if (rd !== exp_rd) begin
                n_err++;
                $display("FAIL %s read word: got %h expected %h", name, rd, exp_rd);
            end
        end
        n_vec++;
        if (busy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy: got %b expected 1", name, busy[k]);
        end
    endtask

    task automatic open_win(input int k);
        ss[k] = 1'b0;
        tick();
    endtask

    task automatic close_win(input int k, input string name);
        ss[k] = 1'b1;
        tick();
        n_vec++;
        if (busy[k] !== 1'b0 || miso[k] !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: got busy=%b miso=%b expected 0/0", name, busy[k], miso[k]);
        end
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (busy[k] !== 1'b0 || miso[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset dut%0d: got busy=%b miso=%b expected 0/0", k, busy[k], miso[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        open_win(0);
        frame(0, 2'b00, 32'h05, 8, 32'h0, "basic waddr");
        frame(0, 2'b01, 32'hA7, 8, 32'h0, "basic wdata");
        frame(0, 2'b10, 32'h05, 8, 32'h0, "basic raddr");
        frame(0, 2'b11, 32'h00, 8, 32'hA7, "basic read");
        // No auto-increment: raddr still 0x05
        frame(0, 2'b11, 32'h00, 8, 32'hA7, "basic reread");
        close_win(0, "basic");
    endtask

    task automatic test_auto_inc();
        open_win(1);
        frame(1, 2'b00, 32'hFE, 8, 32'h0, "inc waddr");
        frame(1, 2'b01, 32'h11, 8, 32'h0, "inc w0");
        frame(1, 2'b01, 32'h22, 8, 32'h0, "inc w1");
        frame(1, 2'b01, 32'h33, 8, 32'h0, "inc w2");
        frame(1, 2'b10, 32'hFE, 8, 32'h0, "inc raddr");
        frame(1, 2'b11, 32'h00, 8, 32'h11, "inc r0");
        frame(1, 2'b11, 32'h00, 8, 32'h22, "inc r1");
        frame(1, 2'b11, 32'h00, 8, 32'h33, "inc r2 wrap");
        close_win(1, "inc");
    endtask

    task automatic test_abort();
        open_win(0);
        frame(0, 2'b00, 32'h10, 8, 32'h0, "abort waddr");
        frame(0, 2'b01, 32'h99, 8, 32'h0, "abort seed");
        send_bits(0, 2'b01, 32'h55, 8, 6);
        close_win(0, "abort");
        open_win(0);
        frame(0, 2'b10, 32'h10, 8, 32'h0, "abort raddr");
        frame(0, 2'b11, 32'h00, 8, 32'h99, "abort keep");
        close_win(0, "abort end");
    endtask

    task automatic test_ss_on_exec();
        open_win(0);
        frame(0, 2'b00, 32'h30, 8, 32'h0, "exec waddr");
        send_bits(0, 2'b01, 32'hC3, 8, 10);
        close_win(0, "exec ss rise");
        open_win(0);
        frame(0, 2'b10, 32'h30, 8, 32'h0, "exec raddr");
        frame(0, 2'b11, 32'h00, 8, 32'hC3, "exec completed");
        close_win(0, "exec end");
    endtask

    task automatic test_out_of_range();
        open_win(2);
        frame(2, 2'b00, 32'hC7, 8, 32'h0, "oor waddr lo");
        frame(2, 2'b01, 32'h5A, 8, 32'h0, "oor w last");
        frame(2, 2'b00, 32'h00, 8, 32'h0, "oor waddr 0");
        frame(2, 2'b01, 32'h3C, 8, 32'h0, "oor w first");
        frame(2, 2'b00, 32'hC8, 8, 32'h0, "oor waddr hi");
        frame(2, 2'b01, 32'h77, 8, 32'h0, "oor w drop");
        frame(2, 2'b10, 32'hC8, 8, 32'h0, "oor raddr hi");
        frame(2, 2'b11, 32'h00, 8, 32'h00, "oor read zero");
        frame(2, 2'b10, 32'hC7, 8, 32'h0, "oor raddr last");
        frame(2, 2'b11, 32'h00, 8, 32'h5A, "oor read last");
        frame(2, 2'b10, 32'h00, 8, 32'h0, "oor raddr 0");
        frame(2, 2'b11, 32'h00, 8, 32'h3C, "oor read first");
        close_win(2, "oor");
    endtask

    task automatic test_reset_mid_tx();
        logic [2:0] rd3;
        rd3 = '0;
        open_win(0);
        frame(0, 2'b00, 32'h22, 8, 32'h0, "rst waddr");
        frame(0, 2'b10, 32'h05, 8, 32'h0, "rst raddr");
        send_bits(0, 2'b11, 32'h00, 8, 10);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            rd3 = {rd3[1:0], miso[0]};
        end
        n_vec++;
        if (rd3 !== 3'b101) begin
            n_err++;
            $display("FAIL rst partial tx: got %b expected 101", rd3);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (miso[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst async: got miso=%b busy=%b expected 0/0", miso[0], busy[0]);
        end
        ss[0] = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        open_win(0);
        // waddr and raddr are both 0 after reset
        frame(0, 2'b01, 32'h6B, 8, 32'h0, "rst w at 0");
        frame(0, 2'b11, 32'h00, 8, 32'h6B, "rst r at 0");
        frame(0, 2'b10, 32'h05, 8, 32'h0, "rst raddr 5");
        frame(0, 2'b11, 32'h00, 8, 32'hA7, "rst mem kept");
        close_win(0, "rst");
    endtask

    task automatic test_wide();
        open_win(3);
        frame(3, 2'b00, 32'h3FF, 16, 32'h0, "wide waddr");
        frame(3, 2'b01, 32'hBEEF, 16, 32'h0, "wide wdata");
        frame(3, 2'b10, 32'h3FF, 16, 32'h0, "wide raddr");
        frame(3, 2'b11, 32'h0, 16, 32'hBEEF, "wide read");
        close_win(3, "wide");
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            ss[k]   = 1'b1;
            mosi[k] = 1'b0;
        end
        test_reset();
        test_basic();
        test_auto_inc();
        test_abort();
        test_ss_on_exec();
        test_out_of_range();
        test_reset_mid_tx();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
